// File: rtl/fpu_ss_mem_buffer.sv
`default_nettype none
// ============================================================================
// fpu_ss_mem_buffer : FIFO of in-flight FP load/store metadata {we, rd, core_id}
// Revision: 1.0
// ============================================================================
module fpu_ss_mem_buffer #(
    parameter int DEPTH     = 4,
    parameter int CORE_ID_W = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    input  logic                         push_we_i,
    input  logic [4:0]                   push_rd_i,
    input  logic [CORE_ID_W-1:0]         push_core_id_i,
    output logic                         pop_valid_o,
    input  logic                         pop_ready_i,
    output logic                         pop_we_o,
    output logic [4:0]                   pop_rd_o,
    output logic [CORE_ID_W-1:0]         pop_core_id_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         underflow_o,
    input  logic                         clear_err_i
);

    localparam int AW      = $clog2(DEPTH);
    localparam int UW      = $clog2(DEPTH+1);
    localparam int ENTRY_W = 1 + 5 + CORE_ID_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]      usage_q, usage_d;
    logic               underflow_q, underflow_d;

    logic               push_fire;
    logic               pop_fire;
    logic               pop_empty;
    logic [ENTRY_W-1:0] head;

    assign full_o       = (usage_q == UW'(DEPTH));
    assign empty_o      = (usage_q == '0);
    assign push_ready_o = ~full_o;
    assign pop_valid_o  = ~empty_o;
    assign usage_o      = usage_q;
    assign underflow_o  = underflow_q;

    assign push_fire = push_valid_i & push_ready_o;
    assign pop_fire  = pop_ready_i & pop_valid_o;
    assign pop_empty = pop_ready_i & empty_o;

    // Head data is forced to zero when empty so stale entries never leak out.
    assign head = empty_o ? '0 : mem_q[rd_ptr_q];
    assign {pop_we_o, pop_rd_o, pop_core_id_o} = head;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        usage_d     = usage_q;
        underflow_d = underflow_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usage_d  = '0;
        end else begin
            // Pointer width equals log2(DEPTH), so natural overflow is the wrap.
            if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_fire && !pop_fire)      usage_d = usage_q + UW'(1);
            else if (pop_fire && !push_fire) usage_d = usage_q - UW'(1);
        end

        if (pop_empty)        underflow_d = 1'b1;
        else if (clear_err_i) underflow_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            usage_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            usage_q     <= usage_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_fire && !flush_i) begin
            mem_q[wr_ptr_q] <= {push_we_i, push_rd_i, push_core_id_i};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_ss_mem_buffer.sv
`default_nettype none
// Directed self-checking bench for fpu_ss_mem_buffer (DEPTH=4, CORE_ID_W=5).
module tb_fpu_ss_mem_buffer;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       flush_i = 1'b0;
    logic       push_valid_i = 1'b0;
    logic       push_ready_o;
    logic       push_we_i = 1'b0;
    logic [4:0] push_rd_i = '0;
    logic [4:0] push_core_id_i = '0;
    logic       pop_valid_o;
    logic       pop_ready_i = 1'b0;
    logic       pop_we_o;
    logic [4:0] pop_rd_o;
    logic [4:0] pop_core_id_o;
    logic [2:0] usage_o;
    logic       full_o;
    logic       empty_o;
    logic       underflow_o;
    logic       clear_err_i = 1'b0;

    int checks = 0;
    int errors = 0;

    fpu_ss_mem_buffer #(.DEPTH(4), .CORE_ID_W(5)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .push_valid_i   (push_valid_i),
        .push_ready_o   (push_ready_o),
        .push_we_i      (push_we_i),
        .push_rd_i      (push_rd_i),
        .push_core_id_i (push_core_id_i),
        .pop_valid_o    (pop_valid_o),
        .pop_ready_i    (pop_ready_i),
        .pop_we_o       (pop_we_o),
        .pop_rd_o       (pop_rd_o),
        .pop_core_id_o  (pop_core_id_o),
        .usage_o        (usage_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .underflow_o    (underflow_o),
        .clear_err_i    (clear_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_push(input logic v, input logic we, input logic [4:0] rd, input logic [4:0] cid);
        push_valid_i   = v;
        push_we_i      = we;
        push_rd_i      = rd;
        push_core_id_i = cid;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while reset is held
        #2;
        chk("rst_push_ready", 32'(push_ready_o), 1);
        chk("rst_pop_valid",  32'(pop_valid_o), 0);
        chk("rst_pop_data",   32'({pop_we_o, pop_rd_o, pop_core_id_o}), 0);
        chk("rst_usage",      32'(usage_o), 0);
        chk("rst_full",       32'(full_o), 0);
        chk("rst_empty",      32'(empty_o), 1);
        chk("rst_underflow",  32'(underflow_o), 0);
        step(); step();
        rst_ni = 1'b1;

        // Single push right after reset; not visible until the next cycle
        set_push(1'b1, 1'b1, 5'd7, 5'd3);
        #1;
        chk("no_fallthrough", 32'(pop_valid_o), 0);
        step();
        set_push(1'b0, 1'b0, 5'd0, 5'd0);
        chk("single_valid", 32'(pop_valid_o), 1);
        chk("single_we",    32'(pop_we_o), 1);
        chk("single_rd",    32'(pop_rd_o), 7);
        chk("single_cid",   32'(pop_core_id_o), 3);
        chk("single_usage", 32'(usage_o), 1);
        pop_ready_i = 1'b1;
        step();
        pop_ready_i = 1'b0;
        chk("single_empty", 32'(empty_o), 1);
        chk("single_zero",  32'(pop_rd_o), 0);
        chk("single_uf",    32'(underflow_o), 0);

        // Fill to DEPTH
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, 1'(i), 5'(10 + i), 5'(i));
            step();
        end
        set_push(1'b0, 1'b0, 5'd0, 5'd0);
        chk("full_flag",  32'(full_o), 1);
        chk("full_ready", 32'(push_ready_o), 0);
        chk("full_usage", 32'(usage_o), 4);
        chk("full_head",  32'(pop_rd_o), 10);

        // Push while full with a simultaneous pop: push is dropped
        set_push(1'b1, 1'b1, 5'd20, 5'd9);
        pop_ready_i = 1'b1;
        step();
        set_push(1'b0, 1'b0, 5'd0, 5'd0);
        pop_ready_i = 1'b0;
        chk("drop_usage", 32'(usage_o), 3);
        chk("drop_head",  32'(pop_rd_o), 11);
        chk("drop_uf",    32'(underflow_o), 0);
        for (int i = 0; i < 3; i++) begin
            chk("drain_rd",  32'(pop_rd_o), 32'(11 + i));
            chk("drain_cid", 32'(pop_core_id_o), 32'(1 + i));
            pop_ready_i = 1'b1;
            step();
        end
        pop_ready_i = 1'b0;
        chk("drain_empty", 32'(empty_o), 1);

        // Interleaved traffic across pointer wrap: heads must come out 0..9
        begin
            int exp_head = 0;
            for (int i = 0; i < 10; i++) begin
                set_push(1'b1, 1'b1, 5'(i), 5'd1);
                if (i >= 2) begin
                    chk("ilv_head", 32'(pop_rd_o), 32'(exp_head));
                    pop_ready_i = 1'b1;
                    exp_head++;
                end
                step();
                pop_ready_i = 1'b0;
                chk("ilv_usage_max", 32'(usage_o <= 3'd4), 1);
            end
            set_push(1'b0, 1'b0, 5'd0, 5'd0);
            for (int i = 0; i < 2; i++) begin
                chk("ilv_tail", 32'(pop_rd_o), 32'(exp_head));
                pop_ready_i = 1'b1;
                exp_head++;
                step();
            end
            pop_ready_i = 1'b0;
            chk("ilv_empty", 32'(empty_o), 1);
        end

        // Underflow: set, set-wins-over-clear, then clear
        pop_ready_i = 1'b1;
        step();
        pop_ready_i = 1'b0;
        chk("uf_set",   32'(underflow_o), 1);
        chk("uf_usage", 32'(usage_o), 0);
        chk("uf_empty", 32'(empty_o), 1);
        pop_ready_i = 1'b1;
        clear_err_i = 1'b1;
        step();
        pop_ready_i = 1'b0;
        chk("uf_set_wins", 32'(underflow_o), 1);
        step();
        clear_err_i = 1'b0;
        chk("uf_clear", 32'(underflow_o), 0);

        // Flush with a same-cycle push; underflow must survive the flush
        pop_ready_i = 1'b1;
        step();
        pop_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_push(1'b1, 1'b0, 5'(i), 5'd2);
            step();
        end
        chk("pre_flush_usage", 32'(usage_o), 3);
        set_push(1'b1, 1'b1, 5'd30, 5'd4);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        set_push(1'b0, 1'b0, 5'd0, 5'd0);
        chk("flush_usage", 32'(usage_o), 0);
        chk("flush_empty", 32'(empty_o), 1);
        chk("flush_valid", 32'(pop_valid_o), 0);
        chk("flush_uf",    32'(underflow_o), 1);
        set_push(1'b1, 1'b1, 5'd5, 5'd6);
        step();
        set_push(1'b1, 1'b0, 5'd6, 5'd7);
        step();
        set_push(1'b0, 1'b0, 5'd0, 5'd0);
        chk("post_flush_head",  32'(pop_rd_o), 5);
        chk("post_flush_cid",   32'(pop_core_id_o), 6);
        chk("post_flush_usage", 32'(usage_o), 2);

        // Asynchronous reset mid-cycle at usage 2
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_usage", 32'(usage_o), 0);
        chk("arst_empty", 32'(empty_o), 1);
        chk("arst_uf",    32'(underflow_o), 0);
        chk("arst_ready", 32'(push_ready_o), 1);
        chk("arst_data",  32'(pop_rd_o), 0);
        #2;
        rst_ni = 1'b1;
        set_push(1'b1, 1'b1, 5'd17, 5'd8);
        step();
        set_push(1'b0, 1'b0, 5'd0, 5'd0);
        chk("arst_first_push", 32'(pop_rd_o), 17);
        chk("arst_first_usage", 32'(usage_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_ss_mem_buffer.md
FPU_SS_MEM_BUFFER -- requirements
Module: fpu_ss_mem_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of metadata entries; power of two, 2 to 16.
REQ-002 SHALL have parameter CORE_ID_W, default 5: width of the core-ID field.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  synchronous discard of all entries.
REQ-006 SHALL have port push_valid_i  input  1  new metadata offered; driven by the controller's mem_push_valid_o.
REQ-007 SHALL have port push_ready_o  output  1  entry can be accepted.
REQ-008 SHALL have port push_we_i  input  1  result writes the FP register file (load).
REQ-009 SHALL have port push_rd_i  input  5  destination register index.
REQ-010 SHALL have port push_core_id_i  input  CORE_ID_W  issuing core ID.
REQ-011 SHALL have port pop_valid_o  output  1  head entry present.
REQ-012 SHALL have port pop_ready_i  input  1  head consumed; driven by the controller's mem_pop_ready_o.
REQ-013 SHALL have ports pop_we_o (1), pop_rd_o (5) and pop_core_id_o (CORE_ID_W)  output  head metadata.
REQ-014 SHALL have port usage_o  output  $clog2(DEPTH+1)  number of valid entries.
REQ-015 SHALL have ports full_o and empty_o  output  1 each  occupancy flags.
REQ-016 SHALL have port underflow_o  output  1  sticky error flag: pop attempted while empty.
REQ-017 SHALL have port clear_err_i  input  1  clears underflow_o.

Function
REQ-018 SHALL store entries {we, rd, core_id} in strict FIFO order, using a write pointer and a read pointer of $clog2(DEPTH) bits plus a usage counter.
REQ-019 SHALL drive push_ready_o = ~full_o; there is no pass-through when full, even if a pop occurs in the same cycle.
REQ-020 SHALL accept a push on the cycle push_valid_i & push_ready_o: the entry is written at the write pointer, and the write pointer and usage are incremented.
REQ-021 SHALL drive pop_valid_o = ~empty_o; the pop_* data SHALL show the head entry when not empty, and all zeros when empty.
REQ-022 SHALL perform a pop on the cycle pop_ready_i & pop_valid_o: the read pointer increments and usage decrements.
REQ-023 SHALL have no fall-through: an entry pushed in cycle N is first visible on the pop_* ports in cycle N+1 (latency 1).
REQ-024 SHALL leave usage unchanged on a simultaneous push and pop; both pointers advance.
REQ-025 SHALL wrap both pointers from DEPTH-1 to 0 with no gap and no lost entry.
REQ-026 SHALL drive full_o = (usage == DEPTH) and empty_o = (usage == 0), both combinational from registered state.
REQ-027 SHALL, when pop_ready_i is high while empty, set underflow_o from the next cycle and leave the pointers and usage unchanged.
REQ-028 SHALL ignore push_valid_i while full; this is not flagged as an error.
REQ-029 SHALL clear underflow_o on clear_err_i, except when a new underflow occurs in the same cycle, in which case set wins.
REQ-030 SHALL, on flush_i, zero both pointers and usage in the next cycle; flush overrides any push or pop in the same cycle, and underflow_o is retained.
REQ-031 SHALL NOT clear the stored entry data on pop or flush; only the pointers and usage define validity.

Reset
REQ-032 SHALL, on rst_ni low, asynchronously clear the pointers, usage and underflow_o, including when reset is asserted mid-operation.
REQ-033 SHALL present these output values during and after reset: push_ready_o=1, pop_valid_o=0, pop_* data=0, usage_o=0, full_o=0, empty_o=1, underflow_o=0.
REQ-034 SHALL accept the first push in the first cycle after rst_ni rises.

Verification
REQ-035 SHALL cover: single push {we=1, rd=7, core_id=3} while empty -> next cycle pop_valid_o=1, pop_rd_o=7, pop_core_id_o=3, usage_o=1; pop -> empty_o=1.
REQ-036 SHALL cover: 4 pushes with DEPTH=4 -> full_o=1, push_ready_o=0; a 5th push plus a simultaneous pop -> 5th push dropped, usage_o=3.
REQ-037 SHALL cover: 10 interleaved pushes and pops with rd values 0-9 -> all popped in order 0-9 across pointer wrap, usage_o never above 4.
REQ-038 SHALL cover: pop_ready_i=1 while empty -> underflow_o=1 next cycle, usage_o=0; clear_err_i together with a new underflow -> underflow_o stays 1; clear_err_i alone -> 0.
REQ-039 SHALL cover: usage 3 with flush_i and push in the same cycle -> usage_o=0, empty_o=1 next cycle, and the pushed entry is discarded.
REQ-040 SHALL cover: rst_ni pulsed low at usage 2 -> immediate usage_o=0, empty_o=1, underflow_o=0.
